led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 The block SHALL have parameter NB_LEDS, default 4, giving the LED pattern width (minimum 4).
REQ-002 The block SHALL have parameter NB_SW, default 3, giving the switch bus width.
REQ-003 The block SHALL have port clock, input, width 1: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_reset, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_sw, input, width NB_SW: bit 0 is run/hold, bits 2:1 are rate select.
REQ-006 The block SHALL have port i_btn, input, width 4: level-sensitive mode request buttons, already synchronised.
REQ-007 The block SHALL have port i_tick, input, width 1: one-cycle step pulse from the rate counter.
REQ-008 The block SHALL have port o_cnt_en, output, width 1: enable to the rate counter.
REQ-009 The block SHALL have port o_rate, output, width 2: rate select to the rate counter.
REQ-010 The block SHALL have port o_leds, output, width NB_LEDS: the current LED pattern.
REQ-011 The block SHALL have port o_mode, output, width 2: current mode encoding.

Function
REQ-012 The block SHALL implement modes SHL=0, SHR=1, FLASH=2 and PING=3 as a registered state machine.
REQ-013 Each i_btn bit SHALL be rising-edge detected against its previous-cycle value; btn[k] requests mode k.
REQ-014 If several button edges occur in one cycle, the lowest index SHALL win.
REQ-015 On an accepted request the mode SHALL update on the next edge and o_leds SHALL load the new mode's seed pattern on that same edge.
REQ-016 Seed patterns: SHL 0...01; SHR 10...0; FLASH all-ones; PING 0...01 with direction set to left.
REQ-017 A request for the current mode SHALL reload that mode's seed.
REQ-018 On each cycle with i_tick=1, i_sw[0]=1 and no accepted request, o_leds SHALL advance one step; otherwise it SHALL hold.
REQ-019 SHL SHALL rotate left with MSB wrapping to bit 0; SHR SHALL rotate right with bit 0 wrapping to the MSB.
REQ-020 FLASH SHALL bitwise-invert o_leds.
REQ-021 PING SHALL shift the single one toward the MSB until it reaches the MSB, then reverse; it reverses again at bit 0, with each end position held for exactly one step.
REQ-022 When a button request and a tick coincide, the request SHALL take priority and the tick SHALL be discarded.
REQ-023 o_cnt_en SHALL equal i_sw[0] and o_rate SHALL equal i_sw[2:1], both registered with one cycle of latency.
REQ-024 When i_sw[0]=0, mode, pattern and PING direction SHALL freeze; button requests SHALL still be accepted.
REQ-025 Exactly one bit of o_leds SHALL be set in SHL, SHR and PING at all times.

Reset
REQ-026 While i_reset=0 the block SHALL immediately force mode SHL, o_leds 0...01, o_mode 0, o_cnt_en 0, o_rate 0, PING direction left and the button history to zero.
REQ-027 Deassertion SHALL take effect at the first following clock edge.
REQ-028 Reset asserted in any mode, including mid-PING, SHALL discard all progress.
REQ-029 A button held high through reset release SHALL NOT generate a request.

Structure
REQ-030 The mode encodings and seed-pattern constants SHALL live in a shared package used by the testbench.
REQ-031 A sub-module edge_det, one instance four bits wide, SHALL perform the button edge detection.
REQ-032 Pattern step logic SHALL be combinational next-state logic feeding a single register bank.
REQ-033 The rate counter SHALL NOT be instantiated inside this block.

Verification
REQ-034 Reset, then i_sw=3'b001 and 5 ticks in SHL -> o_leds 0001, 0010, 0100, 1000, 0001, 0010.
REQ-035 btn[1] pulse, then 2 ticks -> o_leds 1000 after the request, then 0100, 0010; o_mode=1.
REQ-036 PING with 8 ticks -> o_leds 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100 (seed first).
REQ-037 btn[2] rising in the same cycle as i_tick, with btn[3] also rising -> FLASH wins, o_leds 1111, tick ignored; next tick -> 0000.
REQ-038 i_sw[0]=0 with 3 ticks -> o_leds unchanged and o_cnt_en=0 one cycle later; i_sw=3'b111 -> o_rate=3 and o_cnt_en=1 after one cycle.
REQ-039 i_reset pulsed low asynchronously mid-PING with btn[3] held -> outputs reset immediately; after release there is no mode change until btn[3] falls and rises again.

Source files
------------

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared mode encodings and seed patterns for the LED pattern controller.
// Used by the RTL and by the testbench.
package led_pattern_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_FLASH = 2'd2,
        MODE_PING  = 2'd3
    } mode_e;

    localparam int   LED_MAX   = 32;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Seed for a pattern n bits wide; callers cast the result down to n bits.
    function automatic logic [LED_MAX-1:0] seed_pattern(input mode_e m,
                                                        input int unsigned n);
        logic [LED_MAX-1:0] r;
        r = LED_MAX'(1);
        case (m)
            MODE_SHR:   r = LED_MAX'(1) << (n - 1);
            MODE_FLASH: r = '1;
            default:    r = LED_MAX'(1);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_edge_det.sv
// Rising-edge detector for a W-bit level bus.
// Ports: clock, i_reset (async low), i_sig (levels), o_rise (one-cycle edges).
module edge_det #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         i_reset,
    input  logic [W-1:0] i_sig,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;
    logic         arm_q;
    logic         arm_d;

    always_comb begin
        prev_d = i_sig;
        arm_d  = 1'b1;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            prev_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    // The first edge after reset only captures history, so a level held
    // through reset release is not mistaken for a new press.
    assign o_rise = i_sig & ~prev_q & {W{arm_q}};

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: button-selected modes stepping on rate ticks.
// Ports: clock, i_reset (async low), i_sw, i_btn, i_tick -> o_cnt_en, o_rate, o_leds, o_mode.
module led_pattern_ctrl
    import led_pattern_ctrl_pkg::*;
#(
    parameter int NB_LEDS = 4,
    parameter int NB_SW   = 3
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic [3:0]         i_btn,
    input  logic               i_tick,
    output logic               o_cnt_en,
    output logic [1:0]         o_rate,
    output logic [NB_LEDS-1:0] o_leds,
    output logic [1:0]         o_mode
);

    mode_e              mode_q, mode_d;
    logic [NB_LEDS-1:0] leds_q, leds_d;
    logic               dir_q, dir_d;
    logic               cnt_en_q, cnt_en_d;
    logic [1:0]         rate_q, rate_d;

    logic [3:0]         btn_rise;
    logic               req_vld;
    mode_e              req_mode;
    logic               step;

    edge_det #(.W(4)) u_edge_det (
        .clock  (clock),
        .i_reset(i_reset),
        .i_sig  (i_btn),
        .o_rise (btn_rise)
    );

    always_comb begin
        req_mode = MODE_SHL;
        priority case (1'b1)
            btn_rise[0]: req_mode = MODE_SHL;
            btn_rise[1]: req_mode = MODE_SHR;
            btn_rise[2]: req_mode = MODE_FLASH;
            btn_rise[3]: req_mode = MODE_PING;
            default:     req_mode = MODE_SHL;
        endcase
    end

    assign req_vld = |btn_rise;
    assign step    = i_tick & i_sw[0];

    always_comb begin
        mode_d   = mode_q;
        leds_d   = leds_q;
        dir_d    = dir_q;
        cnt_en_d = i_sw[0];
        rate_d   = i_sw[2:1];
        if (req_vld) begin
            // A request swallows any coincident tick.
            mode_d = req_mode;
            leds_d = NB_LEDS'(seed_pattern(req_mode, NB_LEDS));
            dir_d  = DIR_LEFT;
        end else if (step) begin
            case (mode_q)
                MODE_SHL:
                    leds_d = {leds_q[NB_LEDS-2:0], leds_q[NB_LEDS-1]};
                MODE_SHR:
                    leds_d = {leds_q[0], leds_q[NB_LEDS-1:1]};
                MODE_FLASH:
                    leds_d = ~leds_q;
                MODE_PING: begin
                    // Turn around at an end so each end is lit for one step.
                    if (dir_q == DIR_LEFT) begin
                        if (leds_q[NB_LEDS-1]) begin
                            leds_d = leds_q >> 1;
                            dir_d  = DIR_RIGHT;
                        end else begin
                            leds_d = leds_q << 1;
                        end
                    end else begin
                        if (leds_q[0]) begin
                            leds_d = leds_q << 1;
                            dir_d  = DIR_LEFT;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                end
                default: leds_d = leds_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            mode_q   <= MODE_SHL;
            leds_q   <= NB_LEDS'(1);
            dir_q    <= DIR_LEFT;
            cnt_en_q <= 1'b0;
            rate_q   <= 2'd0;
        end else begin
            mode_q   <= mode_d;
            leds_q   <= leds_d;
            dir_q    <= dir_d;
            cnt_en_q <= cnt_en_d;
            rate_q   <= rate_d;
        end
    end

    assign o_cnt_en = cnt_en_q;
    assign o_rate   = rate_q;
    assign o_leds   = leds_q;
    assign o_mode   = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl: scenario tasks with a queue of expected LED values.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_led_pattern_ctrl;
    import led_pattern_ctrl_pkg::*;

    logic       clock = 1'b0;
    logic       i_reset;
    logic [2:0] i_sw;
    logic [3:0] i_btn;
    logic       i_tick;
    logic       o_cnt_en;
    logic [1:0] o_rate;
    logic [3:0] o_leds;
    logic [1:0] o_mode;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e;

    led_pattern_ctrl #(.NB_LEDS(4), .NB_SW(3)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .i_sw    (i_sw),
        .i_btn   (i_btn),
        .i_tick  (i_tick),
        .o_cnt_en(o_cnt_en),
        .o_rate  (o_rate),
        .o_leds  (o_leds),
        .o_mode  (o_mode)
    );

    always #5 clock = ~clock;

    task automatic step(input logic tick, input logic [3:0] btn);
        i_tick = tick;
        i_btn  = btn;
        @(negedge clock);
        i_tick = 1'b0;
    endtask

    task automatic check_leds(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, o_leds);
        end else begin
            e = exp_q.pop_front();
            if (o_leds !== e) begin
                errors++;
                $display("FAIL %s: leds got %b expected %b", name, o_leds, e);
            end
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        i_sw = 3'b000; i_btn = 4'b0; i_tick = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_leds !== 4'b0001 || o_mode !== 2'd0 ||
            o_cnt_en !== 1'b0 || o_rate !== 2'd0) begin
            errors++;
            $display("FAIL reset: leds %b mode %0d en %b rate %0d expected 0001 0 0 0",
                     o_leds, o_mode, o_cnt_en, o_rate);
        end
        @(negedge clock);
        i_reset = 1'b1;
        i_sw = 3'b001;
        step(1'b0, 4'b0);
        checks++;
        if (o_cnt_en !== 1'b1) begin
            errors++;
            $display("FAIL cnt_en_after_reset: got %b expected 1", o_cnt_en);
        end
    endtask

    task automatic test_shl;
        logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_q.push_back(seq[0]);
        check_leds("shl_seed");
        for (int i = 1; i < 6; i++) begin
            exp_q.push_back(seq[i]);
            step(1'b1, 4'b0);
            check_leds("shl_step");
            exp_q.push_back(seq[i]);
            step(1'b0, 4'b0);
            check_leds("shl_hold");
        end
    endtask

    task automatic test_shr;
        exp_q.push_back(4'(seed_pattern(MODE_SHR, 4)));
        step(1'b0, 4'b0010);
        check_leds("shr_seed");
        checks++;
        if (o_mode !== 2'(MODE_SHR)) begin
            errors++;
            $display("FAIL shr_mode: got %0d expected 1", o_mode);
        end
        step(1'b0, 4'b0000);
        exp_q.push_back(4'b0100);
        step(1'b1, 4'b0);
        check_leds("shr_step1");
        exp_q.push_back(4'b0010);
        step(1'b1, 4'b0);
        check_leds("shr_step2");
    endtask

    task automatic test_ping;
        logic [3:0] seq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010, 4'b0100};
        exp_q.push_back(seq[0]);
        step(1'b0, 4'b1000);
        check_leds("ping_seed");
        checks++;
        if (o_mode !== 2'(MODE_PING)) begin
            errors++;
            $display("FAIL ping_mode: got %0d expected 3", o_mode);
        end
        step(1'b0, 4'b0000);
        for (int i = 1; i < 9; i++) begin
            exp_q.push_back(seq[i]);
            step(1'b1, 4'b0);
            check_leds("ping_step");
        end
    endtask

    task automatic test_priority;
        exp_q.push_back(4'b1111);
        step(1'b1, 4'b1100);
        check_leds("prio_flash_seed");
        checks++;
        if (o_mode !== 2'(MODE_FLASH)) begin
            errors++;
            $display("FAIL prio_mode: got %0d expected 2", o_mode);
        end
        step(1'b0, 4'b0000);
        exp_q.push_back(4'b0000);
        step(1'b1, 4'b0);
        check_leds("flash_invert");
        exp_q.push_back(4'b1111);
        step(1'b0, 4'b0100);
        check_leds("flash_reload");
        step(1'b0, 4'b0000);
    endtask

    task automatic test_hold;
        i_sw = 3'b000;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(4'b1111);
            step(1'b1, 4'b0);
            check_leds("hold_frozen");
        end
        checks++;
        if (o_cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL hold_cnt_en: got %b expected 0", o_cnt_en);
        end
        exp_q.push_back(4'b0001);
        step(1'b0, 4'b0001);
        check_leds("hold_request");
        step(1'b0, 4'b0000);
        i_sw = 3'b111;
        #1;
        checks++;
        if (o_rate !== 2'd0 || o_cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL sw_latency: rate %0d en %b expected 0 0", o_rate, o_cnt_en);
        end
        @(negedge clock);
        checks++;
        if (o_rate !== 2'd3 || o_cnt_en !== 1'b1) begin
            errors++;
            $display("FAIL sw_regd: rate %0d en %b expected 3 1", o_rate, o_cnt_en);
        end
    endtask

    task automatic test_async_reset;
        i_sw = 3'b001;
        step(1'b0, 4'b1000);
        step(1'b1, 4'b1000);
        exp_q.push_back(4'b0100);
        step(1'b1, 4'b1000);
        check_leds("ping_pre_reset");
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_leds !== 4'b0001 || o_mode !== 2'd0 ||
            o_cnt_en !== 1'b0 || o_rate !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: leds %b mode %0d en %b rate %0d expected 0001 0 0 0",
                     o_leds, o_mode, o_cnt_en, o_rate);
        end
        @(negedge clock);
        @(negedge clock);
        i_reset = 1'b1;
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1000);
        checks++;
        if (o_mode !== 2'd0 || o_leds !== 4'b0001) begin
            errors++;
            $display("FAIL held_btn: mode %0d leds %b expected 0 0001", o_mode, o_leds);
        end
        step(1'b0, 4'b0000);
        step(1'b0, 4'b1000);
        checks++;
        if (o_mode !== 2'(MODE_PING)) begin
            errors++;
            $display("FAIL repress: mode %0d expected 3", o_mode);
        end
        exp_q.push_back(4'b0010);
        step(1'b1, 4'b1000);
        check_leds("ping_after_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_shl();
        test_shr();
        test_ping();
        test_priority();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
